// File: rtl/minutes_entry.sv
// minutes_entry: push-button minute entry front end for the countdown timer.
//
// The three raw buttons are synchronized and debounced. The user presses set to
// start editing, dials a two-digit BCD value 00..MAX_MIN with up/down, and
// presses set again to hand the value to the timer with a stretched load strobe.
// That strobe is long enough for the slow 1 Hz timer domain to sample it.
//
// Optional feature macro: MINUTES_ENTRY_AUTOREPEAT_EN
//   When defined, holding up or down (not both) in EDIT produces an extra step
//   REP_DELAY cycles after the press, and then one step every REP_RATE cycles.
//   When undefined, no repeat logic is built.
//
// Ports:
//   clk        in   board clock
//   reset      in   synchronous active-high reset
//   btn_set    in   raw asynchronous button
//   btn_up     in   raw asynchronous button
//   btn_down   in   raw asynchronous button
//   I1         out  BCD tens digit of entered minutes
//   I0         out  BCD units digit of entered minutes
//   load       out  stretched load strobe to the timer
//   editing    out  high while in EDIT
//   entry_zero out  high when I1:I0 == 00
module minutes_entry #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int LOAD_HOLD = 150_000_000,
    parameter int MAX_MIN   = 99,
    parameter int REP_DELAY = 50_000_000,
    parameter int REP_RATE  = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] I1,
    output logic [3:0] I0,
    output logic       load,
    output logic       editing,
    output logic       entry_zero
);

    localparam int BTN_SET  = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;

    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HOLD_W = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LOAD_HOLD - 1);
    localparam logic [7:0]        MAX_BCD   = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    // Reject parameter sets the datapath cannot represent.
    if (DB_CYCLES < 1 || LOAD_HOLD < 1 || MAX_MIN < 1 || MAX_MIN > 99 ||
        REP_RATE < 1 || REP_DELAY < REP_RATE) begin : g_bad_cfg
        $error("minutes_entry: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Two-digit BCD step with wrap at MAX_MIN; digits never leave 0..9.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == MAX_BCD)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return MAX_BCD;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      stable;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    assign raw = {btn_down, btn_up, btn_set};

    // Synchronize, then accept a change only after it persists DB_CYCLES cycles.
    // press is a one-cycle pulse registered on the accepted 0->1 transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            press  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    press[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_next;
    logic [7:0]        val_next;
    logic              up_step;
    logic              down_step;

`ifdef MINUTES_ENTRY_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REP_DELAY + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_held;
    logic             rep_fire;

    // Counts cycles a single direction button is held in EDIT; after the first
    // fire it is rewound so later fires come every REP_RATE cycles.
    assign rep_held = (state == EDIT) && (stable[BTN_UP] != stable[BTN_DOWN]);
    assign rep_fire = rep_held && (rep_cnt == REP_W'(REP_DELAY));

    always_ff @(posedge clk) begin
        if (reset || !rep_held)
            rep_cnt <= '0;
        else if (rep_fire)
            rep_cnt <= REP_W'(REP_DELAY - REP_RATE);
        else
            rep_cnt <= rep_cnt + REP_W'(1);
    end

    assign up_step   = press[BTN_UP]   | (rep_fire & stable[BTN_UP]);
    assign down_step = press[BTN_DOWN] | (rep_fire & stable[BTN_DOWN]);
`else
    assign up_step   = press[BTN_UP];
    assign down_step = press[BTN_DOWN];
`endif

    always_comb begin
        state_next = state;
        hold_next  = hold;
        val_next   = {I1, I0};
        case (state)
            IDLE: begin
                if (press[BTN_SET]) state_next = EDIT;
            end
            EDIT: begin
                // set has priority; up together with down cancels out
                if (press[BTN_SET]) begin
                    state_next = LOAD;
                    hold_next  = HOLD_INIT;
                end else if (up_step && !down_step) begin
                    val_next = bcd_inc({I1, I0});
                end else if (down_step && !up_step) begin
                    val_next = bcd_dec({I1, I0});
                end
            end
            LOAD: begin
                if (hold == '0)
                    state_next = IDLE;
                else
                    hold_next = hold - HOLD_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold     <= '0;
            {I1, I0} <= 8'h00;
        end else begin
            state    <= state_next;
            hold     <= hold_next;
            {I1, I0} <= val_next;
        end
    end

    assign load       = (state == LOAD);
    assign editing    = (state == EDIT);
    assign entry_zero = ({I1, I0} == 8'h00);

endmodule

// File: tb/tb_minutes_entry.sv
// Testbench for minutes_entry: randomized and directed button presses, with a
// cycle-timed reference model feeding an expectation queue that a separate
// monitor drains whenever the DUT outputs change.
module tb_minutes_entry;

    localparam int DB   = 4;
    localparam int LH   = 8;
    localparam int MAXM = 99;
    localparam int RD   = 20;
    localparam int RR   = 5;
    localparam int NSCH = 20000;

    localparam bit [2:0] M_SET  = 3'b001;
    localparam bit [2:0] M_UP   = 3'b010;
    localparam bit [2:0] M_DOWN = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_set;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] I1;
    logic [3:0] I0;
    logic       load;
    logic       editing;
    logic       entry_zero;

    minutes_entry #(
        .DB_CYCLES(DB),
        .LOAD_HOLD(LH),
        .MAX_MIN  (MAXM),
        .REP_DELAY(RD),
        .REP_RATE (RR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_set   (btn_set),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .I1        (I1),
        .I0        (I0),
        .load      (load),
        .editing   (editing),
        .entry_zero(entry_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] i1;
        logic [3:0] i0;
        logic       ld;
        logic       ed;
        logic       ez;
    } snap_t;

    int       checks   = 0;
    int       failures = 0;
    int       cyc      = 0;
    bit       mon_en   = 1'b0;
    bit [2:0] sched [NSCH];   // button presses as seen by the FSM, per cycle
    snap_t    exq [$];

    function automatic bit snap_eq(input snap_t a, input snap_t b);
        return (a.i1 === b.i1) && (a.i0 === b.i0) && (a.ld === b.ld) &&
               (a.ed === b.ed) && (a.ez === b.ez);
    endfunction

    // Reference model: the entry is an integer 0..MAXM, LOAD lasts LH cycles.
    initial begin : model
        int       st;
        int       val;
        int       lstart;
        bit [2:0] p;
        snap_t    s;
        snap_t    last;
        st     = 0;
        val    = 0;
        lstart = 0;
        last   = '{0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            p   = (cyc < NSCH) ? sched[cyc] : 3'b000;
            if (reset) begin
                st  = 0;
                val = 0;
            end else begin
                case (st)
                    0: if (p[0]) st = 1;
                    1: begin
                        if (p[0]) begin
                            st     = 2;
                            lstart = cyc;
                        end else if (p[1] && !p[2]) begin
                            val = (val + 1) % (MAXM + 1);
                        end else if (p[2] && !p[1]) begin
                            val = (val + MAXM) % (MAXM + 1);
                        end
                    end
                    default: if (cyc - lstart >= LH) st = 0;
                endcase
            end
            s.cyc = cyc;
            s.i1  = 4'(val / 10);
            s.i0  = 4'(val % 10);
            s.ld  = (st == 2);
            s.ed  = (st == 1);
            s.ez  = (val == 0);
            if (!snap_eq(s, last)) begin
                if (mon_en) exq.push_back(s);
                last = s;
            end
        end
    end

    // Monitor: every observed output change must match the next expectation.
    initial begin : monitor
        snap_t cur;
        snap_t prev;
        snap_t e;
        prev = '{0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        wait (mon_en);
        forever begin
            @(negedge clk);
            cur = '{cyc, I1, I0, load, editing, entry_zero};
            if (!snap_eq(cur, prev)) begin
                checks++;
                if (exq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got I1I0=%h%h load=%b editing=%b zero=%b, required no change",
                             cur.cyc, cur.i1, cur.i0, cur.ld, cur.ed, cur.ez);
                end else begin
                    e = exq.pop_front();
                    if (!snap_eq(cur, e) || cur.cyc != e.cyc) begin
                        failures++;
                        $display("FAIL output_event cyc got=%0d required=%0d I1I0 got=%h%h required=%h%h load got=%b required=%b editing got=%b required=%b zero got=%b required=%b",
                                 cur.cyc, e.cyc, cur.i1, cur.i0, e.i1, e.i0, cur.ld, e.ld, cur.ed, e.ed, cur.ez, e.ez);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic drive(input bit [2:0] mask, input logic v);
        if (mask[0]) btn_set  = v;
        if (mask[1]) btn_up   = v;
        if (mask[2]) btn_down = v;
    endtask

    // Raw press held len cycles, then released for gap cycles. A press held at
    // least DB cycles reaches the FSM DB+3 edges after the raw edge.
    task automatic press(input bit [2:0] mask, input int len, input int gap);
        int n;
        n = cyc;
        drive(mask, 1'b1);
        if (len >= DB && n + DB + 3 < NSCH) sched[n + DB + 3] |= mask;
`ifdef MINUTES_ENTRY_AUTOREPEAT_EN
        if (len >= DB && (mask == M_UP || mask == M_DOWN)) begin
            // held from the first step until the release is debounced
            for (int t = n + DB + 3 + RD; t <= n + len + DB + 2 && t < NSCH; t += RR)
                sched[t] |= mask;
        end
`endif
        repeat (len) @(negedge clk);
        drive(mask, 1'b0);
        repeat (gap) @(negedge clk);
    endtask

    initial begin : stimulus
        int       n;
        int       r;
        int       len;
        int       gap;
        bit [2:0] m;
        reset    = 1'b1;
        btn_set  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_I1", 32'(I1), 32'd0);
        chk("reset_I0", 32'(I0), 32'd0);
        chk("reset_load", 32'(load), 32'd0);
        chk("reset_editing", 32'(editing), 32'd0);
        chk("reset_entry_zero", 32'(entry_zero), 32'd1);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        press(M_SET, 5, 12);                 // IDLE -> EDIT
        press(M_UP, 3, 12);                  // glitch, ignored
        press(M_UP, 10, 12);                 // 01
        press(M_DOWN, 6, 12);                // 00
        press(M_DOWN, 6, 12);                // 99
        press(M_UP, 6, 12);                  // 00
        repeat (10) press(M_UP, 5, 10);      // 10
        press(M_DOWN, 5, 10);                // 09
        repeat (11) press(M_UP, 5, 10);      // 20
        repeat (5) press(M_UP, 5, 10);       // 25

        // set, then an up press that lands during LOAD
        n = cyc;
        btn_set = 1'b1;
        sched[n + DB + 3] |= M_SET;
        repeat (4) @(negedge clk);
        btn_set = 1'b0;
        n = cyc;
        btn_up = 1'b1;
        sched[n + DB + 3] |= M_UP;
        repeat (5) @(negedge clk);
        btn_up = 1'b0;
        repeat (20) @(negedge clk);

        press(M_UP, 6, 12);                  // IDLE ignores up
        press(M_SET, 6, 12);                 // EDIT
        press(M_UP | M_DOWN, 6, 12);         // cancels
        press(M_SET | M_UP, 6, 20);          // set wins -> LOAD, value kept
        press(M_SET, 6, 12);                 // EDIT

        // reset in the third LOAD cycle
        n = cyc;
        btn_set = 1'b1;
        sched[n + DB + 3] |= M_SET;
        repeat (4) @(negedge clk);
        btn_set = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_load_load", 32'(load), 32'd0);
        chk("reset_mid_load_value", 32'({I1, I0}), 32'h00);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        // long hold of up in EDIT
        press(M_SET, 6, 12);
        press(M_UP, 46, 30);
        press(M_SET, 6, 20);                 // LOAD -> IDLE

        repeat (150) begin
            r   = $urandom_range(0, 9);
            m   = (r <= 3) ? M_UP : (r <= 6) ? M_DOWN : (r == 7) ? M_SET :
                  (r == 8) ? (M_UP | M_DOWN) : (M_SET | M_UP);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB - 1) : $urandom_range(DB, DB + 6);
            gap = $urandom_range(DB + 4, DB + 12);
            press(m, len, gap);
        end

        repeat (LH + DB + 20) @(negedge clk);
        checks++;
        if (exq.size() != 0) begin
            failures++;
            $display("FAIL drain pending_events got=%0d required=0", exq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
